// File: rtl/ifft8_stream.sv
// Streaming 8-point inverse FFT on IEEE-754 single complex samples: serial load,
// one combinational fft8 pass on the conjugated frame, conjugate and /8, serial unload.

module fft8 (
    input  logic [7:0][31:0] a_re,
    input  logic [7:0][31:0] a_im,
    input  logic [3:0][31:0] w_re,
    input  logic [3:0][31:0] w_im,
    output logic [7:0][31:0] c_re,
    output logic [7:0][31:0] c_im,
    output logic             ex
);
    // Arithmetic flushes denormals to zero and truncates; any NaN operand yields NaN.
    function automatic logic [31:0] fneg(input logic [31:0] a);
        return {~a[31], a[30:0]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC00000;
        if (a[30:23] == '0 || b[30:23] == '0) return {s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e++;
            m = p[46:24];
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), m};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [25:0] mx, my, diff;
        logic [26:0] sum;
        int          e, d, lz;
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return b;
        if (b[30:23] == '0) return (a[30:23] == '0) ? {a[31] & b[31], 31'd0} : a;
        if (a[30:23] == '0) return b;
        {x, y} = (a[30:0] >= b[30:0]) ? {a, b} : {b, a};
        e  = int'(x[30:23]);
        d  = e - int'(y[30:23]);
        mx = {1'b1, x[22:0], 2'b00};
        my = (d > 25) ? '0 : ({1'b1, y[22:0], 2'b00} >> d);
        if (x[31] == y[31]) begin
            sum = {1'b0, mx} + {1'b0, my};
            if (sum[26]) begin
                e++;
                if (e >= 255) return {x[31], 8'hFF, 23'd0};
                return {x[31], 8'(e), sum[25:3]};
            end
            return {x[31], 8'(e), sum[24:2]};
        end
        diff = mx - my;
        if (diff == '0) return '0;
        lz = 0;
        for (int unsigned i = 0; i < 26; i++)
            if (diff[i]) lz = 25 - int'(i);
        e = e - lz;
        if (e <= 0) return {x[31], 31'd0};
        diff = diff << lz;
        return {x[31], 8'(e), diff[24:2]};
    endfunction

    logic [31:0] v_re [0:3][0:7];
    logic [31:0] v_im [0:3][0:7];
    logic [31:0] t_re, t_im;
    logic [2:0]  lo, hi;
    logic [1:0]  k;

    // Radix-2 DIT: bit-reversed input, spans 1/2/4, twiddle W^(j mod span * 4/span)
    always_comb begin
        v_re = '{default: '0};
        v_im = '{default: '0};
        t_re = '0;
        t_im = '0;
        lo   = '0;
        hi   = '0;
        k    = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            v_re[0][3'(i)] = a_re[{i[0], i[1], i[2]}];
            v_im[0][3'(i)] = a_im[{i[0], i[1], i[2]}];
        end
        for (int unsigned s = 0; s < 3; s++) begin
            for (int unsigned j = 0; j < 8; j++) begin
                if ((j & (32'd1 << s)) == 0) begin
                    lo = 3'(j);
                    hi = 3'(j + (32'd1 << s));
                    k  = 2'((j & ((32'd1 << s) - 1)) << (2 - s));
                    t_re = fadd(fmul(v_re[2'(s)][hi], w_re[k]), fneg(fmul(v_im[2'(s)][hi], w_im[k])));
                    t_im = fadd(fmul(v_re[2'(s)][hi], w_im[k]), fmul(v_im[2'(s)][hi], w_re[k]));
                    v_re[2'(s + 1)][lo] = fadd(v_re[2'(s)][lo], t_re);
                    v_im[2'(s + 1)][lo] = fadd(v_im[2'(s)][lo], t_im);
                    v_re[2'(s + 1)][hi] = fadd(v_re[2'(s)][lo], fneg(t_re));
                    v_im[2'(s + 1)][hi] = fadd(v_im[2'(s)][lo], fneg(t_im));
                end
            end
        end
        ex = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            c_re[3'(i)] = v_re[3][3'(i)];
            c_im[3'(i)] = v_im[3][3'(i)];
            ex = ex | (v_re[3][3'(i)][30:23] == 8'hFF) | (v_im[3][3'(i)][30:23] == 8'hFF);
        end
    end
endmodule

module ifft8_stream #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_re,
    input  logic [31:0] in_im,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_re,
    output logic [31:0] out_im,
    output logic [2:0]  out_index,
    output logic        out_last,
    output logic        exc,
    output logic        busy
);
    typedef enum logic [1:0] {LOAD, SETTLE, UNLOAD} state_t;

    state_t           state, state_nx;
    logic [2:0]       wr_idx, rd_idx;
    logic [3:0]       cnt;
    logic [7:0][31:0] ib_re, ib_im, ob_re, ob_im, a_im, c_re, c_im, post_re, post_im;
    logic [3:0][31:0] w_re, w_im;
    logic [32:0]      sr, si;
    logic             fft_ex, uf_any, exc_q, in_fire, out_fire, settle_done;

    // Divide by 8 via exponent only; bit 32 of the result flags an underflow to zero.
    function automatic logic [32:0] scale8(input logic [31:0] w);
        if (w[30:23] == 8'hFF) return {1'b0, w};
        if (w[30:23] == '0) return {1'b0, w[31], 31'd0};
        if (w[30:23] < 8'd4) return {1'b1, w[31], 31'd0};
        return {1'b0, w[31], w[30:23] - 8'd3, w[22:0]};
    endfunction

    assign w_re = {32'hBF3504F3, 32'h00000000, 32'h3F3504F3, 32'h3F800000};
    assign w_im = {32'hBF3504F3, 32'hBF800000, 32'hBF3504F3, 32'h00000000};

    always_comb begin
        for (int unsigned i = 0; i < 8; i++)
            a_im[3'(i)] = {~ib_im[3'(i)][31], ib_im[3'(i)][30:0]};
    end

    fft8 u_fft8 (
        .a_re (ib_re),
        .a_im (a_im),
        .w_re (w_re),
        .w_im (w_im),
        .c_re (c_re),
        .c_im (c_im),
        .ex   (fft_ex)
    );

    always_comb begin
        uf_any = 1'b0;
        sr     = '0;
        si     = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            sr = scale8(c_re[3'(i)]);
            si = scale8({~c_im[3'(i)][31], c_im[3'(i)][30:0]});
            post_re[3'(i)] = sr[31:0];
            post_im[3'(i)] = si[31:0];
            uf_any = uf_any | sr[32] | si[32];
        end
    end

    assign in_ready    = rst_n && (state == LOAD);
    assign out_valid   = (state == UNLOAD);
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign settle_done = (state == SETTLE) && (cnt == 4'(SETTLE_CYCLES - 1));
    assign out_re      = out_valid ? ob_re[rd_idx] : '0;
    assign out_im      = out_valid ? ob_im[rd_idx] : '0;
    assign out_index   = rd_idx;
    assign out_last    = out_valid && (rd_idx == 3'd7);
    assign exc         = out_valid && exc_q;
    assign busy        = (state != LOAD);

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (in_fire && wr_idx == 3'd7) state_nx = SETTLE;
            SETTLE:  if (settle_done) state_nx = UNLOAD;
            UNLOAD:  if (out_fire && rd_idx == 3'd7) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            cnt    <= '0;
            exc_q  <= 1'b0;
        end else begin
            if (in_fire) begin
                ib_re[wr_idx] <= in_re;
                ib_im[wr_idx] <= in_im;
                wr_idx        <= wr_idx + 3'd1;
            end
            cnt <= (state == SETTLE) ? cnt + 4'd1 : '0;
            if (settle_done) begin
                ob_re <= post_re;
                ob_im <= post_im;
                exc_q <= fft_ex | uf_any;
            end
            if (out_fire) rd_idx <= rd_idx + 3'd1;
        end
    end
endmodule

// File: tb/tb_ifft8_stream.sv
// Directed self-checking bench for ifft8_stream: vector table of frames with
// real-valued expected outputs, plus reset, latency and backpressure sequences.

module tb_ifft8_stream;
    localparam int S = 2;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_re = '0, in_im = '0;
    logic        in_ready, out_valid, out_last, exc, busy;
    logic [31:0] out_re, out_im;
    logic [2:0]  out_index;

    always #5 clk = ~clk;

    ifft8_stream #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_index(out_index), .out_last(out_last),
        .exc(exc), .busy(busy)
    );

    typedef struct {
        logic [7:0][31:0] re, im;
        logic [7:0][63:0] xr, xi;
        real              tol;
        bit               exc;
        bit               vals;
    } vec_t;

    vec_t        vecs[5];
    int          checks = 0, errors = 0, lat;
    logic [31:0] got_re[24], got_im[24];
    bit          got_exc[24];

    function automatic real b2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == '0) return 0.0;
        d = {b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2b(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return '0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic real fabs(input real r);
        return (r < 0.0) ? -r : r;
    endfunction

    task automatic chk(input bit ok, input string name, input real act, input real exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %g expected %g", name, act, exp);
        end
    endtask

    task automatic push_sample(input logic [31:0] re, input logic [31:0] im);
        bit done = 0;
        int n = 0;
        in_valid = 1'b1;
        in_re = re;
        in_im = im;
        while (!done && n < 300) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!done) chk(1'b0, "in_accept_timeout", n, 300);
    endtask

    task automatic push_frame(input logic [7:0][31:0] re, input logic [7:0][31:0] im, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            push_sample(re[i], im[i]);
        end
    endtask

    task automatic collect(input int n, input bit toggle);
        int          got = 0, cyc = 0;
        bit          have_hold = 0;
        logic [31:0] h_re = '0, h_im = '0;
        logic [2:0]  h_idx = '0;
        lat = -1;
        out_ready = 1'b1;
        while (got < n && cyc < n * 10 + 60) begin
            @(negedge clk);
            if (have_hold) begin
                chk(out_valid && out_re == h_re && out_im == h_im && out_index == h_idx,
                    "output_hold", out_re, h_re);
                have_hold = 0;
            end
            if (out_valid) begin
                if (lat < 0) lat = cyc;
                chk(!in_ready && busy, "in_ready_low_busy_during_unload", in_ready, 0);
                if (out_ready) begin
                    chk(out_index == 3'(got % 8), "out_index", out_index, got % 8);
                    chk(out_last == (got % 8 == 7), "out_last", out_last, (got % 8 == 7));
                    got_re[got] = out_re;
                    got_im[got] = out_im;
                    got_exc[got] = exc;
                    got++;
                end else begin
                    h_re = out_re;
                    h_im = out_im;
                    h_idx = out_index;
                    have_hold = 1;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            out_ready = toggle ? ~out_ready : 1'b1;
        end
        if (got < n) chk(1'b0, "output_timeout", got, n);
        @(negedge clk);
        chk(in_ready && !out_valid, "in_ready_after_last", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        real ar[8], ai[8], peak, th, xr, xi;
        logic [7:0][31:0] fr, fz;

        // vector table
        for (int v = 0; v < 5; v++) begin
            vecs[v].re = '0; vecs[v].im = '0; vecs[v].xr = '0; vecs[v].xi = '0;
            vecs[v].tol = 0.0; vecs[v].exc = 0; vecs[v].vals = 1;
        end
        vecs[0].re[0] = 32'h41000000;
        for (int n = 0; n < 8; n++) vecs[0].xr[n] = $realtobits(1.0);
        vecs[1].re[1] = 32'h41000000;
        vecs[1].tol = 1e-6;
        for (int n = 0; n < 8; n++) begin
            vecs[1].xr[n] = $realtobits($cos(3.14159265358979 * n / 4.0));
            vecs[1].xi[n] = $realtobits($sin(3.14159265358979 * n / 4.0));
        end
        peak = 0.0;
        for (int i = 0; i < 8; i++) begin
            ar[i] = 2.0 * i * i / 3.0 - 7.562;
            ai[i] = 16.0 * i / 5.152 - 1.0 * i * i * i;
            if (fabs(ar[i]) > peak) peak = fabs(ar[i]);
            if (fabs(ai[i]) > peak) peak = fabs(ai[i]);
            vecs[2].xr[i] = $realtobits(ar[i]);
            vecs[2].xi[i] = $realtobits(ai[i]);
        end
        for (int k = 0; k < 8; k++) begin
            xr = 0.0; xi = 0.0;
            for (int n = 0; n < 8; n++) begin
                th = 2.0 * 3.14159265358979 * k * n / 8.0;
                xr += ar[n] * $cos(th) + ai[n] * $sin(th);
                xi += ai[n] * $cos(th) - ar[n] * $sin(th);
            end
            vecs[2].re[k] = r2b(xr);
            vecs[2].im[k] = r2b(xi);
        end
        vecs[2].tol = 1e-4 * peak;
        vecs[3].re[0] = r2b(8e-38);
        vecs[3].exc = 1;
        vecs[4].re[0] = 32'h7FC00000;
        vecs[4].exc = 1;
        vecs[4].vals = 0;

        // power-up reset, partial frame, then a 3-cycle reset with in_valid held high
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        fr = '0;
        for (int i = 0; i < 5; i++) push_sample(32'h40400000, 32'h3F800000);
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_re = 32'h40A00000;
        repeat (3) begin
            @(negedge clk);
            chk(!in_ready, "reset_in_ready", in_ready, 0);
            chk(!out_valid, "reset_out_valid", out_valid, 0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk(in_ready, "release_in_ready", in_ready, 1);
        chk(out_re == '0 && out_im == '0, "reset_out_data", out_re, 0);
        chk(out_index == '0 && !out_last, "reset_index_last", out_index, 0);
        chk(!exc && !busy, "reset_exc_busy", busy, 0);
        @(posedge clk);
        #1;

        // table-driven frames
        for (int v = 0; v < 5; v++) begin
            push_frame(vecs[v].re, vecs[v].im, 1'b0);
            collect(8, 1'b0);
            chk(lat == S, $sformatf("latency_v%0d", v), lat, S);
            for (int n = 0; n < 8; n++) begin
                if (vecs[v].vals) begin
                    chk(fabs(b2r(got_re[n]) - $bitstoreal(vecs[v].xr[n])) <= vecs[v].tol,
                        $sformatf("re_v%0d_n%0d", v, n), b2r(got_re[n]), $bitstoreal(vecs[v].xr[n]));
                    chk(fabs(b2r(got_im[n]) - $bitstoreal(vecs[v].xi[n])) <= vecs[v].tol,
                        $sformatf("im_v%0d_n%0d", v, n), b2r(got_im[n]), $bitstoreal(vecs[v].xi[n]));
                end
                chk(got_exc[n] == vecs[v].exc, $sformatf("exc_v%0d_n%0d", v, n), got_exc[n], vecs[v].exc);
            end
        end
        chk(got_re[3][30:23] == 8'hFF, "nan_propagates", got_re[3], 32'h7FC00000);

        // three back-to-back tone frames (bins 1,2,3) with input gaps and ready toggling
        fork
            for (int f = 0; f < 3; f++) begin
                fr = '0;
                fz = '0;
                fr[f + 1] = 32'h41000000;
                push_frame(fr, fz, 1'b1);
            end
            collect(24, 1'b1);
        join
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 8; n++) begin
                th = 3.14159265358979 * (f + 1) * n / 4.0;
                chk(fabs(b2r(got_re[f * 8 + n]) - $cos(th)) <= 1e-6,
                    $sformatf("bp_re_f%0d_n%0d", f, n), b2r(got_re[f * 8 + n]), $cos(th));
                chk(fabs(b2r(got_im[f * 8 + n]) - $sin(th)) <= 1e-6,
                    $sformatf("bp_im_f%0d_n%0d", f, n), b2r(got_im[f * 8 + n]), $sin(th));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
